// File: rtl/eth_tx_pkg.sv
// Shared types for the GMII TX arbiter: FSM state encoding and idle data byte.
// Latency: n/a (types only).  Backpressure: n/a.
package eth_tx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_ARP = 2'd1,
    GRANT_UDP = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam logic [7:0] IDLE_TXD = 8'h00;

endpackage

// File: rtl/eth_tx_rr_pick.sv
// Two-way round-robin select: a lone request wins, a tie goes to the source not granted last.
// Latency: combinational.  Backpressure: none; the picks are advisory to the arbiter FSM.
module eth_tx_rr_pick (
  input  logic arp_req,
  input  logic udp_req,
  input  logic last_udp,
  output logic pick_arp,
  output logic pick_udp
);

  assign pick_arp = arp_req && (!udp_req || last_udp);
  assign pick_udp = udp_req && (!arp_req || !last_udp);

endmodule

// File: rtl/eth_tx_arbiter.sv
// Grants the GMII TX bus to the ARP or UDP transmitter; ETH_TX_IFG_EN adds an inter-frame GAP state.
// Latency: sel one edge after request in IDLE, GMII data one cycle.  Backpressure: holders keep the bus until done or timeout.
module eth_tx_arbiter
  import eth_tx_pkg::*;
#(
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       gmii_tx_clk,
  input  logic       rst,
  input  logic       arp_tx_req,
  output logic       arp_tx_sel,
  input  logic       arp_tx_done,
  input  logic       arp_gmii_tx_en,
  input  logic [7:0] arp_gmii_txd,
  input  logic       udp_tx_req,
  output logic       udp_tx_sel,
  input  logic       udp_tx_done,
  input  logic       udp_gmii_tx_en,
  input  logic [7:0] udp_gmii_txd,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       timeout_err
);

  if (IFG_CYCLES < 1 || IFG_CYCLES > 255) begin : g_bad_ifg
    $error("eth_tx_arbiter: IFG_CYCLES out of range 1..255");
  end
  if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("eth_tx_arbiter: TIMEOUT_CYCLES out of range 16..65535");
  end

  state_t      state;
  state_t      release_state;
  logic [15:0] grant_cnt;
  logic        last_udp;
  logic        pick_arp;
  logic        pick_udp;
  logic        in_grant;
  logic        granted_done;
  logic        timeout_hit;

  eth_tx_rr_pick u_rr_pick (
    .arp_req  (arp_tx_req),
    .udp_req  (udp_tx_req),
    .last_udp (last_udp),
    .pick_arp (pick_arp),
    .pick_udp (pick_udp)
  );

  assign in_grant     = (state == GRANT_ARP) || (state == GRANT_UDP);
  assign granted_done = ((state == GRANT_ARP) && arp_tx_done) ||
                        ((state == GRANT_UDP) && udp_tx_done);
  assign timeout_hit  = in_grant && (grant_cnt == 16'(TIMEOUT_CYCLES - 1));
  // Timeout must be masked by a same-cycle done, so it cannot be registered ahead of time.
  assign timeout_err  = timeout_hit && !granted_done;

`ifdef ETH_TX_IFG_EN
  logic [7:0] gap_cnt;
  assign release_state = GAP;
`else
  assign release_state = IDLE;
`endif

  always_ff @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_cnt  <= '0;
      last_udp   <= 1'b1;
      arp_tx_sel <= 1'b0;
      udp_tx_sel <= 1'b0;
`ifdef ETH_TX_IFG_EN
      gap_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          grant_cnt <= '0;
          if (pick_arp) begin
            state      <= GRANT_ARP;
            arp_tx_sel <= 1'b1;
            last_udp   <= 1'b0;
          end else if (pick_udp) begin
            state      <= GRANT_UDP;
            udp_tx_sel <= 1'b1;
            last_udp   <= 1'b1;
          end
        end
        GRANT_ARP, GRANT_UDP: begin
          if (granted_done || timeout_hit) begin
            state      <= release_state;
            arp_tx_sel <= 1'b0;
            udp_tx_sel <= 1'b0;
`ifdef ETH_TX_IFG_EN
            gap_cnt    <= '0;
`endif
          end else begin
            grant_cnt <= grant_cnt + 16'd1;
          end
        end
`ifdef ETH_TX_IFG_EN
        GAP: begin
          if (gap_cnt == 8'(IFG_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
`endif
        default: begin
          state      <= IDLE;
          arp_tx_sel <= 1'b0;
          udp_tx_sel <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) begin
      gmii_tx_en <= 1'b0;
      gmii_txd   <= IDLE_TXD;
    end else begin
      case (state)
        GRANT_ARP: begin
          gmii_tx_en <= arp_gmii_tx_en;
          gmii_txd   <= arp_gmii_txd;
        end
        GRANT_UDP: begin
          gmii_tx_en <= udp_gmii_tx_en;
          gmii_txd   <= udp_gmii_txd;
        end
        default: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= IDLE_TXD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: a vector table for a full ARP frame plus sequences for
// round-robin, timeout, done/timeout precedence, mid-frame reset and grant-after-done spacing.
module tb_eth_tx_arbiter;

`ifdef ETH_TX_IFG_EN
  localparam int GRANT_DLY = 12 + 2;
`else
  localparam int GRANT_DLY = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       arp_tx_req, arp_tx_done, arp_gmii_tx_en;
  logic [7:0] arp_gmii_txd;
  logic       udp_tx_req, udp_tx_done, udp_gmii_tx_en;
  logic [7:0] udp_gmii_txd;
  logic       arp_tx_sel, udp_tx_sel, gmii_tx_en, timeout_err;
  logic [7:0] gmii_txd;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  eth_tx_arbiter #(.IFG_CYCLES(12), .TIMEOUT_CYCLES(16)) dut (
    .gmii_tx_clk    (clk),
    .rst            (rst),
    .arp_tx_req     (arp_tx_req),
    .arp_tx_sel     (arp_tx_sel),
    .arp_tx_done    (arp_tx_done),
    .arp_gmii_tx_en (arp_gmii_tx_en),
    .arp_gmii_txd   (arp_gmii_txd),
    .udp_tx_req     (udp_tx_req),
    .udp_tx_sel     (udp_tx_sel),
    .udp_tx_done    (udp_tx_done),
    .udp_gmii_tx_en (udp_gmii_tx_en),
    .udp_gmii_txd   (udp_gmii_txd),
    .gmii_tx_en     (gmii_tx_en),
    .gmii_txd       (gmii_txd),
    .timeout_err    (timeout_err)
  );

  typedef struct {
    logic       ar, ad, ae;
    logic [7:0] ax;
    logic       ur, ud, ue;
    logic [7:0] ux;
    logic       xa, xu, xe;
    logic [7:0] xd;
    logic       xt;
  } vec_t;

  vec_t tv[11];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    arp_tx_req = 0; arp_tx_done = 0; arp_gmii_tx_en = 0; arp_gmii_txd = 8'h00;
    udp_tx_req = 0; udp_tx_done = 0; udp_gmii_tx_en = 0; udp_gmii_txd = 8'h00;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    chk("rst_arp_sel", int'(arp_tx_sel), 0);
    chk("rst_udp_sel", int'(udp_tx_sel), 0);
    chk("rst_tx_en", int'(gmii_tx_en), 0);
    chk("rst_txd", int'(gmii_txd), 0);
    chk("rst_terr", int'(timeout_err), 0);
    rst = 0;
  endtask

  int n;
  int first;
  logic cur_udp;
  logic exp_src[3];

  initial begin
    //        ar ad ae ax     ur ud ue ux     xa xu xe xd     xt
    tv[0]  = '{1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0};
    tv[1]  = '{1, 0, 1, 8'h55, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0};
    tv[2]  = '{0, 0, 1, 8'h55, 0, 0, 0, 8'h00, 1, 0, 1, 8'h55, 0};
    tv[3]  = '{0, 0, 1, 8'h55, 1, 1, 1, 8'hAA, 1, 0, 1, 8'h55, 0};
    tv[4]  = '{0, 0, 1, 8'h55, 0, 0, 0, 8'h00, 1, 0, 1, 8'h55, 0};
    tv[5]  = '{0, 0, 1, 8'h55, 0, 0, 0, 8'h00, 1, 0, 1, 8'h55, 0};
    tv[6]  = '{0, 0, 1, 8'h55, 0, 0, 0, 8'h00, 1, 0, 1, 8'h55, 0};
    tv[7]  = '{0, 0, 1, 8'h55, 0, 0, 0, 8'h00, 1, 0, 1, 8'h55, 0};
    tv[8]  = '{0, 1, 1, 8'hD5, 0, 0, 0, 8'h00, 1, 0, 1, 8'h55, 0};
    tv[9]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 8'hD5, 0};
    tv[10] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0};

    // ARP frame after reset; stray UDP request/done mid-frame must be ignored.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      arp_tx_req = tv[i].ar; arp_tx_done = tv[i].ad; arp_gmii_tx_en = tv[i].ae; arp_gmii_txd = tv[i].ax;
      udp_tx_req = tv[i].ur; udp_tx_done = tv[i].ud; udp_gmii_tx_en = tv[i].ue; udp_gmii_txd = tv[i].ux;
      @(negedge clk);
      chk($sformatf("v%0d_arp_sel", i), int'(arp_tx_sel), int'(tv[i].xa));
      chk($sformatf("v%0d_udp_sel", i), int'(udp_tx_sel), int'(tv[i].xu));
      chk($sformatf("v%0d_tx_en", i), int'(gmii_tx_en), int'(tv[i].xe));
      chk($sformatf("v%0d_txd", i), int'(gmii_txd), int'(tv[i].xd));
      chk($sformatf("v%0d_terr", i), int'(timeout_err), int'(tv[i].xt));
      tick();
    end

    // Both requests held: ARP, UDP, ARP with the inter-frame spacing between grants.
    do_reset();
    exp_src = '{1'b0, 1'b1, 1'b0};
    arp_tx_req = 1; udp_tx_req = 1;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      while (!(arp_tx_sel || udp_tx_sel) && n < 40) begin tick(); n++; end
      if (f > 0) chk($sformatf("rr_idle_cycles_%0d", f), n, GRANT_DLY - 1);
      chk($sformatf("rr_src_udp_%0d", f), int'(udp_tx_sel), int'(exp_src[f]));
      chk($sformatf("rr_one_hot_%0d", f), int'(arp_tx_sel) + int'(udp_tx_sel), 1);
      cur_udp = udp_tx_sel;
      for (int k = 0; k < 7; k++) tick();
      if (cur_udp) udp_tx_done = 1; else arp_tx_done = 1;
      tick();
      arp_tx_done = 0; udp_tx_done = 0;
    end
    clear_inputs();

    // Timeout: UDP holds the bus and never finishes.
    do_reset();
    udp_tx_req = 1; udp_gmii_tx_en = 1; udp_gmii_txd = 8'hAA;
    n = 0;
    while (!udp_tx_sel && n < 40) begin tick(); n++; end
    chk("to_grant_delay", n, 1);
    udp_tx_req = 0;
    first = 0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      if (timeout_err) first = k;
      else tick();
    end
    chk("to_pulse_cycle", first, 16);
    chk("to_sel_during_pulse", int'(udp_tx_sel), 1);
    tick();
    chk("to_sel_dropped", int'(udp_tx_sel), 0);
    chk("to_pulse_single", int'(timeout_err), 0);
    tick();
    chk("to_tx_en_off", int'(gmii_tx_en), 0);
    clear_inputs();

    // Done in the timeout cycle wins and suppresses timeout_err.
    do_reset();
    arp_tx_req = 1;
    n = 0;
    while (!arp_tx_sel && n < 40) begin tick(); n++; end
    arp_tx_req = 0;
    for (int k = 0; k < 15; k++) tick();
    arp_tx_done = 1;
    #1;
    chk("prec_terr_low", int'(timeout_err), 0);
    tick();
    arp_tx_done = 0;
    chk("prec_sel_dropped", int'(arp_tx_sel), 0);
    chk("prec_terr_after", int'(timeout_err), 0);

    // Reset in the middle of a UDP frame, then a tie must go to ARP.
    do_reset();
    udp_tx_req = 1; udp_gmii_tx_en = 1; udp_gmii_txd = 8'h5A;
    n = 0;
    while (!udp_tx_sel && n < 40) begin tick(); n++; end
    tick();
    tick();
    chk("mid_tx_en_before", int'(gmii_tx_en), 1);
    #2;
    rst = 1;
    #1;
    chk("mid_udp_sel_async", int'(udp_tx_sel), 0);
    chk("mid_tx_en_async", int'(gmii_tx_en), 0);
    chk("mid_txd_async", int'(gmii_txd), 0);
    clear_inputs();
    tick();
    rst = 0;
    arp_tx_req = 1; udp_tx_req = 1;
    tick();
    chk("mid_tie_arp", int'(arp_tx_sel), 1);
    chk("mid_tie_not_udp", int'(udp_tx_sel), 0);
    clear_inputs();

    // Grant spacing after done with the next requester already waiting.
    do_reset();
    arp_tx_req = 1;
    n = 0;
    while (!arp_tx_sel && n < 40) begin tick(); n++; end
    arp_tx_req = 0; udp_tx_req = 1;
    tick();
    tick();
    arp_tx_done = 1;
    tick();
    arp_tx_done = 0;
    n = 1;
    while (!udp_tx_sel && n < 40) begin
      chk($sformatf("gap_no_arp_%0d", n), int'(arp_tx_sel), 0);
      tick();
      n++;
    end
    chk("done_to_udp_sel", n, GRANT_DLY);
    chk("done_udp_sel_high", int'(udp_tx_sel), 1);
    clear_inputs();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
